// File: rtl/alu.sv
// alu: single-cycle 32-bit ALU. The result and flags are computed from a, b and aluop, then registered.
// Ports: clk, rst_n (async low), a/b operands, aluop[3:0]; outputs c[31:0], zero[1:0] {bgtz_taken, is_zero}.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluop,
    output logic [31:0] c,
    output logic [1:0]  zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_LUI  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_BGTZ = 4'b1100;

    logic [4:0]  w_shamt;
    logic        w_a_pos;
    logic        w_bgtz;
    logic [31:0] w_res;
    logic [1:0]  w_flags;

    logic [31:0] r_c;
    logic [1:0]  r_zero;

    assign w_shamt = b[4:0];
    // Signed a > 0: sign bit clear and not all zero.
    assign w_a_pos = ~a[31] & (|a);
    assign w_bgtz  = (aluop == OP_BGTZ) & w_a_pos;

    always_comb begin
        w_res = 32'd0;
        unique case (aluop)
            OP_ADD:  w_res = a + b;
            OP_SUB:  w_res = a - b;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $signed(a) >>> w_shamt;
            OP_LUI:  w_res = {b[15:0], 16'h0000};
            OP_SLT:  w_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: w_res = {31'd0, a < b};
            OP_BGTZ: w_res = {31'd0, w_a_pos};
            default: w_res = 32'd0;
        endcase
    end

    assign w_flags = {w_bgtz, (w_res == 32'd0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c    <= 32'd0;
            r_zero <= 2'b01;
        end else begin
            r_c    <= w_res;
            r_zero <= w_flags;
        end
    end

    assign c    = r_c;
    assign zero = r_zero;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu, with a behavioural reference model.
// A single compare process checks DUT outputs against the model every cycle plus literal expectations.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluop;
    logic [31:0] c;
    logic [1:0]  zero;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .aluop (aluop),
        .c     (c),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: outputs derived from the opcode rules as plain arithmetic.
    function automatic logic [33:0] model(input logic [3:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        logic        taken;
        longint      sx;
        longint      sy;
        int          sh;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        sh    = int'(y % 32);
        taken = 1'b0;
        case (op)
            4'd0:  r = 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
            4'd1:  r = 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000);
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ~(x | y);
            4'd6:  r = 32'((longint'(x) * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd7:  r = 32'(longint'(x) / (64'd1 << sh));
            // Arithmetic shift as floor division of the signed value.
            4'd8:  r = 32'((sx >= 0) ? sx / (64'sd1 <<< sh)
                                     : -((-sx + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh)));
            4'd9:  r = 32'(longint'(y % 65536) * 65536);
            4'd10: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd11: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
            4'd12: begin
                taken = (sx > 0);
                r     = taken ? 32'd1 : 32'd0;
            end
            default: r = 32'd0;
        endcase
        return {taken, (r == 32'd0), r};
    endfunction

    logic [33:0] exp_q = {2'b01, 32'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= {2'b01, 32'd0};
        else        exp_q <= model(aluop, a, b);
    end

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          lit_id = 0;
    int          seen_id = 0;
    string       lit_name = "";
    logic [33:0] lit_exp = '0;

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        total_cnt++;
        if ({zero, c} !== exp_q)
            $display("FAIL model t=%0t: got zero=%b c=%h, want zero=%b c=%h",
                     $time, zero, c, exp_q[33:32], exp_q[31:0]);
        else
            pass_cnt++;
        if (lit_id != seen_id) begin
            seen_id = lit_id;
            total_cnt++;
            if ({zero, c} !== lit_exp)
                $display("FAIL %s: got zero=%b c=%h, want zero=%b c=%h",
                         lit_name, zero, c, lit_exp[33:32], lit_exp[31:0]);
            else
                pass_cnt++;
        end
    end

    task automatic expect_lit(input string nm, input logic [1:0] z, input logic [31:0] v);
        lit_name = nm;
        lit_exp  = {z, v};
        lit_id++;
    endtask

    // Apply one op, let one edge capture it, then scramble inputs mid-cycle.
    task automatic step(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input string nm, input logic [1:0] z, input logic [31:0] v);
        aluop = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        expect_lit(nm, z, v);
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b1;
        a     = 32'd0;
        b     = 32'd0;
        aluop = 4'd0;
        #1 rst_n = 1'b0;
        #2;
        expect_lit("reset_state", 2'b01, 32'd0);
        @(negedge clk);
        #2;
        a     = 32'd5;
        b     = 32'd4;
        aluop = 4'd0;
        rst_n = 1'b1;

        step(4'd0,  32'd5,         32'd4,         "add_5_4",   2'b00, 32'd9);
        step(4'd1,  32'd5,         32'd4,         "sub_5_4",   2'b00, 32'd1);
        step(4'd1,  32'd5,         32'd5,         "sub_5_5",   2'b01, 32'd0);
        step(4'd6,  32'hFF000000,  32'd4,         "sll",       2'b00, 32'hF0000000);
        step(4'd8,  32'hFF000000,  32'd4,         "sra",       2'b00, 32'hFFF00000);
        step(4'd7,  32'hFF000000,  32'd4,         "srl",       2'b00, 32'h0FF00000);
        step(4'd10, 32'hFFFFFFFF,  32'd0,         "slt_neg",   2'b00, 32'd1);
        step(4'd11, 32'hFFFFFFFF,  32'd0,         "sltu",      2'b01, 32'd0);
        step(4'd12, 32'd5,         32'hDEAD,      "bgtz_5",    2'b10, 32'd1);
        step(4'd12, 32'h80000000,  32'd0,         "bgtz_min",  2'b01, 32'd0);
        step(4'd12, 32'd0,         32'd7,         "bgtz_0",    2'b01, 32'd0);
        step(4'd4,  32'h0F0F0F0F,  32'h0C0C0C0C,  "xor",       2'b00, 32'h03030303);
        step(4'd5,  32'd0,         32'd0,         "nor",       2'b00, 32'hFFFFFFFF);
        step(4'd9,  32'hFFFF,      32'h00001234,  "lui",       2'b00, 32'h12340000);
        step(4'd8,  32'h80000000,  32'hFFFFFFFF,  "sra_31",    2'b00, 32'hFFFFFFFF);
        step(4'd6,  32'h1,         32'hFFFFFFE4,  "sll_hi_b",  2'b00, 32'h10);
        step(4'd0,  32'hFFFFFFFF,  32'd1,         "add_wrap",  2'b01, 32'd0);
        step(4'd13, 32'd5,         32'd4,         "unused_13", 2'b01, 32'd0);

        // Asynchronous reset between edges while c is nonzero.
        aluop = 4'd0;
        a     = 32'd5;
        b     = 32'd4;
        @(posedge clk);
        #1;
        expect_lit("pre_reset", 2'b00, 32'd9);
        @(negedge clk);
        #2;
        expect_lit("async_reset", 2'b01, 32'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        aluop = 4'd1;
        a     = 32'd7;
        b     = 32'd2;
        @(posedge clk);
        #1;
        expect_lit("post_reset", 2'b00, 32'd5);
        @(negedge clk);
        #2;

        vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'd1});
        vecs.push_back('{4'd1,  32'd0,        32'd1});
        vecs.push_back('{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0});
        vecs.push_back('{4'd3,  32'd0,        32'd0});
        vecs.push_back('{4'd7,  32'h80000000, 32'd31});
        vecs.push_back('{4'd8,  32'h7FFFFFFF, 32'd30});
        vecs.push_back('{4'd10, 32'd3,        32'hFFFFFFFE});
        vecs.push_back('{4'd10, 32'h80000000, 32'h7FFFFFFF});
        vecs.push_back('{4'd11, 32'd3,        32'hFFFFFFFE});
        vecs.push_back('{4'd12, 32'h7FFFFFFF, 32'd0});
        vecs.push_back('{4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{4'd15, 32'h12345678, 32'h9});
        vecs.push_back('{4'd9,  32'd0,        32'hFFFF0000});
        for (int i = 0; i < vecs.size(); i++) begin
            aluop = vecs[i].op;
            a     = vecs[i].x;
            b     = vecs[i].y;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 20; i++) begin
            aluop = 4'($urandom_range(0, 15));
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the opcode width at 4 bits.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a  input  32  operand A; also the shift source and the BGTZ test value.
REQ-005 b  input  32  operand B; b[4:0] is the shift amount and b[15:0] is the LUI immediate.
REQ-006 aluop  input  4  operation select, encoded per REQ-009.
REQ-007 c  output  32  registered result.
REQ-008 zero  output  2  registered flags; zero[0] = result-is-zero, zero[1] = BGTZ taken.

Function
REQ-009 Opcodes:
- ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101
- SLL=0110, SRL=0111, SRA=1000, LUI=1001
- SLT=1010, SLTU=1011, BGTZ=1100
REQ-010 ADD/SUB SHALL compute a+b and a-b modulo 2^32, with no overflow flag or trap.
REQ-011 AND/OR/XOR/NOR SHALL be bitwise; NOR SHALL be ~(a|b).
REQ-012 SLL SHALL be a<<b[4:0] and SRL SHALL be a logical right shift by b[4:0] (zero fill).
REQ-013 SRA SHALL be an arithmetic right shift of a by b[4:0], filling with a[31]; b[31:5] SHALL be ignored for all shifts.
REQ-014 LUI SHALL give {b[15:0],16'h0000}; a is ignored.
REQ-015 SLT SHALL give 32'd1 if signed a < signed b, else 32'd0.
REQ-016 SLTU SHALL give 32'd1 if unsigned a < unsigned b, else 32'd0.
REQ-017 BGTZ SHALL give 32'd1 if signed a > 0, else 32'd0; b is ignored.
REQ-018 Unused opcodes 1101-1111 SHALL give result 32'd0.
REQ-019 The next-state flag zero[0] SHALL be 1 iff the computed result equals 32'd0, for every opcode.
REQ-020 The next-state flag zero[1] SHALL be 1 iff aluop==BGTZ and signed a > 0; for all other opcodes it SHALL be 0.
REQ-021 The result and flags SHALL be computed combinationally from a, b and aluop as sampled at a rising clk edge, and SHALL be registered into c and zero on that edge.
REQ-022 Latency SHALL be exactly 1 cycle, with a new operation accepted every cycle and no handshake.
REQ-023 c and zero SHALL hold their values between edges, even if the inputs change.
REQ-024 Inputs changing mid-cycle SHALL have no effect until the next rising edge.

Reset
REQ-025 While rst_n=0, c SHALL be 32'd0 and zero SHALL be 2'b01, asynchronously.
REQ-026 Reset asserted mid-operation SHALL immediately discard the pending result.
REQ-027 The first rising edge after rst_n deasserts SHALL capture the current inputs normally.

Verification
REQ-028 Each check SHALL be made one edge after applying the stimulus:
- ADD a=5,b=4 -> c=9, zero=00.
- SUB a=5,b=4 -> c=1, zero=00.
- SUB a=5,b=5 -> c=0, zero=01.
REQ-029 Shift checks with a=32'hFF000000, b=4:
- SLL -> c=32'hF0000000.
- SRA -> c=32'hFFF00000.
- SRL -> c=32'h0FF00000.
REQ-030 Signed/unsigned compare checks:
- SLT a=32'hFFFFFFFF, b=0 -> c=1 (-1<0).
- SLTU with the same operands -> c=0, zero=01.
REQ-031 BGTZ checks:
- a=5 -> c=1, zero=10.
- a=32'h80000000 -> c=0, zero=01.
- a=0 -> c=0, zero=01.
REQ-032 Logic and LUI checks:
- XOR a=32'h0F0F0F0F, b=32'h0C0C0C0C -> c=32'h03030303.
- NOR a=0, b=0 -> c=32'hFFFFFFFF.
- LUI b=32'h00001234 -> c=32'h12340000.
REQ-033 Reset check: assert rst_n=0 between clock edges while c is nonzero -> c=0 and zero=01 without waiting for an edge; after release, the next edge yields the correct result.
